proc_sequencer: RTL and testbench
=================================

# proc_sequencer

Multi-cycle control sequencer for the single-issue processor datapath: it steps each instruction through fetch, decode, execute, memory and write-back. It drives the IR, PC and register-file write strobes. It handshakes with instruction and data memory and counts retired instructions. It sits beside the Decoder, consumes its instruction-class flags and the ALU condition bit, and stops the core on illegal opcodes or memory timeouts.

## Interface
- `WORD_SIZE`, default `` `WORD_SIZE `` (32): width of the retired-instruction counter.
- `MEM_TIMEOUT`, default 16: maximum wait, in cycles, for `imem_ack` or `dmem_ack`. Minimum 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch data valid this cycle.
- `ir_wrtEn`  out  1  load the instruction register.
- `dec_illegal`, `dec_is_load`, `dec_is_store`, `dec_is_branch`, `dec_is_jump`, `dec_wrtEn`  in  1 each  Decoder class flags for the current IR.
- `alu_cond`  in  1  branch condition from the ALU (1 = taken).
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data memory write (store).
- `dmem_ack`  in  1  data access complete.
- `pc_wrtEn`  out  1  update the PC.
- `pc_sel`  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target.
- `regfile_wrtEn`  out  1  register-file write strobe.
- `wb_sel`  out  1  write-back source: 0 = ALU, 1 = memory data.
- `halted`  out  1  core stopped.
- `halt_cause`  out  2  reason for halt: 0 = none, 1 = illegal, 2 = imem timeout, 3 = dmem timeout.
- `retired`  out  WORD_SIZE  count of completed instructions.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH
  - `imem_req`=1 while in the state.
  - On `imem_ack`: `ir_wrtEn`=1 in that same cycle, then go to DECODE.
- DECODE (1 cycle)
  - `dec_illegal` → HALT, cause 1.
  - Otherwise → EXEC.
- EXEC (1 cycle)
  - Load or store → MEM.
  - Jump → `pc_wrtEn`=1, `pc_sel`=2, retire, → FETCH.
  - Branch → `pc_wrtEn`=1, `pc_sel` = `alu_cond`?1:0, retire, → FETCH.
  - `dec_wrtEn` → WB.
  - Otherwise (nop class) → `pc_wrtEn`=1, `pc_sel`=0, retire, → FETCH.
  - Flag priority: load/store > jump > branch > wrtEn.
- MEM
  - `dmem_req`=1 while in the state; `dmem_we` = `dec_is_store`.
  - On `dmem_ack`, store → `pc_wrtEn`=1, `pc_sel`=0, retire, → FETCH.
  - On `dmem_ack`, load → WB.
- WB (1 cycle)
  - `regfile_wrtEn`=1, `wb_sel` = `dec_is_load`.
  - `pc_wrtEn`=1, `pc_sel`=0, retire, → FETCH.
- HALT
  - Terminal; only `reset` leaves it.
  - All strobes are 0; `halted`=1; `halt_cause` holds its value.
- Watchdog
  - Counts the cycles spent in FETCH or MEM; cleared on every state entry.
  - If the count reaches `MEM_TIMEOUT` with no ack: → HALT, cause 2 (FETCH) or 3 (MEM).
  - An ack arriving in the last allowed cycle (count = `MEM_TIMEOUT`-1) is accepted.
- `retired` increments by 1 on each retire cycle and wraps modulo 2^WORD_SIZE.
- Strobes (`ir_wrtEn`, `pc_wrtEn`, `regfile_wrtEn`) are combinational from state and inputs. They are single-cycle pulses, never held.

## Timing
- While `reset` is high, on each rising edge:
  - state ← FETCH, `retired` ← 0, `halt_cause` ← 0, watchdog ← 0.
  - All outputs read 0, except in the first post-reset FETCH cycle, where `imem_req`=1.
- Reset asserted mid-instruction (any state, including HALT) aborts it with no retire and no register write.
- Latency from FETCH entry to retire, with zero-wait acks (ack in the first request cycle):
  - branch/jump/nop: 3 cycles.
  - ALU op: 4 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
  - Each wait cycle on a memory ack adds 1.
- Requests: `imem_req`/`dmem_req` rise in the first cycle of the state and stay high until the ack cycle inclusive. They drop the following cycle.
- An ack seen outside FETCH/MEM is ignored.
- The Decoder flags are sampled only in DECODE, EXEC, MEM and WB. They are stable there because the IR is written only in FETCH.

## Structure
- Shared header `Sequencer.vh`: state encodings, `pc_sel` codes, `halt_cause` codes.
- One sub-module, `mem_watchdog`:
  - Counter sized by clog2(`MEM_TIMEOUT`)+1.
  - Inputs: `clear`, `enable`.
  - Output: `expired`.
  - Used for both the FETCH and MEM waits.
- The FSM and the retire counter live in `proc_sequencer`.

## Test plan
- ALU op, zero-wait ack: FETCH→DECODE→EXEC→WB→FETCH. `regfile_wrtEn`=1 and `wb_sel`=0 in cycle 4; `retired` 0→1.
- Load with `dmem_ack` after 3 wait cycles:
  - `dmem_req` high for 4 cycles, `dmem_we`=0.
  - WB with `wb_sel`=1; total 8 cycles; `retired`=1.
- Branch cases:
  - `alu_cond`=1 → `pc_sel`=1 in EXEC.
  - `alu_cond`=0 → `pc_sel`=0.
  - Neither retire asserts `regfile_wrtEn`.
- `dec_illegal`=1 → HALT after DECODE:
  - `halted`=1, `halt_cause`=1.
  - Later acks are ignored; `retired` is unchanged.
- Watchdog:
  - `imem_ack` withheld 16 cycles (`MEM_TIMEOUT`=16) → HALT, cause 2.
  - Ack on cycle 16 is accepted normally.
  - Same for MEM → cause 3.
- Reset and wrap:
  - Reset asserted in MEM → next cycle FETCH with `retired`=0, no write strobe.
  - With WORD_SIZE=4, 16 retires → `retired` wraps to 0.

Source files
------------

// File: rtl/proc_sequencer_pkg.sv
// Shared encodings for the multi-cycle processor sequencer.
package proc_sequencer_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  // PC source select
  localparam logic [1:0] PcSelSeq    = 2'd0;  // PC + 4
  localparam logic [1:0] PcSelBranch = 2'd1;
  localparam logic [1:0] PcSelJump   = 2'd2;

  // Halt reasons
  localparam logic [1:0] HaltNone    = 2'd0;
  localparam logic [1:0] HaltIllegal = 2'd1;
  localparam logic [1:0] HaltImemTo  = 2'd2;
  localparam logic [1:0] HaltDmemTo  = 2'd3;

endpackage

// File: rtl/proc_sequencer_mem_watchdog.sv
// Wait-cycle watchdog shared by the instruction-fetch and data-access waits.
module proc_sequencer_mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expires in the last allowed wait cycle so the FSM can still prefer an ack.
  assign expired = enable && (cnt_q == LastCnt);

  // Next count: clear on state entry, count while waiting, hold once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle control sequencer: fetch, decode, execute, memory, write-back.
module proc_sequencer
  import proc_sequencer_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic                 ir_wrtEn,
  input  logic                 dec_illegal,
  input  logic                 dec_is_load,
  input  logic                 dec_is_store,
  input  logic                 dec_is_branch,
  input  logic                 dec_is_jump,
  input  logic                 dec_wrtEn,
  input  logic                 alu_cond,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  output logic                 pc_wrtEn,
  output logic [1:0]           pc_sel,
  output logic                 regfile_wrtEn,
  output logic                 wb_sel,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [WORD_SIZE-1:0] retired
);

  state_e               state_q, state_d;
  logic [1:0]           halt_cause_q, halt_cause_d;
  logic [WORD_SIZE-1:0] retired_q, retired_d;
  logic                 retire;
  logic                 wd_expired;

  proc_sequencer_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_d != state_q),
    .enable ((state_q == StFetch || state_q == StMem) && !reset),
    .expired(wd_expired)
  );

  // Next-state and strobe decode; every strobe is forced low while reset is held.
  always_comb begin
    state_d       = state_q;
    halt_cause_d  = halt_cause_q;
    imem_req      = 1'b0;
    ir_wrtEn      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    pc_wrtEn      = 1'b0;
    pc_sel        = PcSelSeq;
    regfile_wrtEn = 1'b0;
    wb_sel        = 1'b0;
    halted        = 1'b0;

    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_wrtEn = 1'b1;
          state_d  = StDecode;
        end else if (wd_expired) begin
          state_d      = StHalt;
          halt_cause_d = HaltImemTo;
        end
      end
      StDecode: begin
        if (dec_illegal) begin
          state_d      = StHalt;
          halt_cause_d = HaltIllegal;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (dec_is_load || dec_is_store) begin
          state_d = StMem;
        end else if (dec_is_jump) begin
          pc_wrtEn = 1'b1;
          pc_sel   = PcSelJump;
          state_d  = StFetch;
        end else if (dec_is_branch) begin
          pc_wrtEn = 1'b1;
          pc_sel   = alu_cond ? PcSelBranch : PcSelSeq;
          state_d  = StFetch;
        end else if (dec_wrtEn) begin
          state_d = StWb;
        end else begin
          pc_wrtEn = 1'b1;
          state_d  = StFetch;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = dec_is_store;
        if (dmem_ack) begin
          if (dec_is_store) begin
            pc_wrtEn = 1'b1;
            state_d  = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (wd_expired) begin
          state_d      = StHalt;
          halt_cause_d = HaltDmemTo;
        end
      end
      StWb: begin
        regfile_wrtEn = 1'b1;
        wb_sel        = dec_is_load;
        pc_wrtEn      = 1'b1;
        state_d       = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    if (reset) begin
      imem_req      = 1'b0;
      ir_wrtEn      = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      pc_wrtEn      = 1'b0;
      pc_sel        = PcSelSeq;
      regfile_wrtEn = 1'b0;
      wb_sel        = 1'b0;
      halted        = 1'b0;
    end

    // Every retire path, and only a retire, updates the PC.
    retire = pc_wrtEn;
  end

  // Retire counter, wrapping naturally at its width.
  always_comb begin
    retired_d = retired_q + WORD_SIZE'(retire);
  end

  // State, halt reason and retire count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFetch;
      halt_cause_q <= HaltNone;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      halt_cause_q <= halt_cause_d;
      retired_q    <= retired_d;
    end
  end

  assign halt_cause = halt_cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer: stimulus pushes the expected output vector of every
// active cycle; a negedge monitor pops and compares whenever the DUT shows activity.
module tb_proc_sequencer;

  localparam int ClsNop    = 0;
  localparam int ClsAlu    = 1;
  localparam int ClsLoad   = 2;
  localparam int ClsStore  = 3;
  localparam int ClsBranch = 4;
  localparam int ClsJump   = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       imem_ack = 1'b0, dmem_ack = 1'b0;
  logic       dec_illegal = 1'b0, dec_is_load = 1'b0, dec_is_store = 1'b0;
  logic       dec_is_branch = 1'b0, dec_is_jump = 1'b0, dec_wrtEn = 1'b0, alu_cond = 1'b0;
  logic       imem_req, ir_wrtEn, dmem_req, dmem_we, pc_wrtEn, regfile_wrtEn, wb_sel, halted;
  logic [1:0] pc_sel, halt_cause;
  logic [3:0] retired;

  typedef struct packed {
    int         cyc;
    logic       imr;
    logic       irw;
    logic       dmr;
    logic       dmw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rfw;
    logic       wbs;
    logic       hlt;
    logic [1:0] cause;
    logic [3:0] ret;
  } vec_t;

  vec_t  exp_q[$];
  string name_q[$];
  string cur_name = "reset";
  int    n_vec = 0, n_err = 0;
  int    cyc = 0;
  bit    probe = 1'b0, done = 1'b0;
  logic  [3:0] exp_ret = 4'd0;
  logic  [1:0] exp_cause = 2'd0;
  logic  exp_hlt = 1'b0, exp_hlt_prev = 1'b0;
  logic  [6:0] nxt_flags = 7'd0;
  bit    load_flags = 1'b0;
  logic  mon_hlt_prev = 1'b0;

  proc_sequencer #(
    .WORD_SIZE  (4),
    .MEM_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .ir_wrtEn     (ir_wrtEn),
    .dec_illegal  (dec_illegal),
    .dec_is_load  (dec_is_load),
    .dec_is_store (dec_is_store),
    .dec_is_branch(dec_is_branch),
    .dec_is_jump  (dec_is_jump),
    .dec_wrtEn    (dec_wrtEn),
    .alu_cond     (alu_cond),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .pc_wrtEn     (pc_wrtEn),
    .pc_sel       (pc_sel),
    .regfile_wrtEn(regfile_wrtEn),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .halt_cause   (halt_cause),
    .retired      (retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic imr, input logic irw, input logic dmr, input logic dmw,
                              input logic pcw, input logic [1:0] pcs, input logic rfw,
                              input logic wbs);
    vec_t v;
    v = '0;
    v.imr = imr; v.irw = irw; v.dmr = dmr; v.dmw = dmw;
    v.pcw = pcw; v.pcs = pcs; v.rfw = rfw; v.wbs = wbs;
    return v;
  endfunction

  function automatic string fmt(input vec_t v);
    return $sformatf("cyc=%0d imr=%b irw=%b dmr=%b dmw=%b pcw=%b pcs=%0d rfw=%b wbs=%b hlt=%b cause=%0d ret=%0d",
                     v.cyc, v.imr, v.irw, v.dmr, v.dmw, v.pcw, v.pcs, v.rfw, v.wbs, v.hlt,
                     v.cause, v.ret);
  endfunction

  // One clock cycle: drive inputs just after the edge and record what this cycle must show.
  task automatic tick(input logic rst, input logic ia, input logic da, input vec_t e,
                      input bit prb);
    @(posedge clk);
    #1;
    reset    = rst;
    imem_ack = ia;
    dmem_ack = da;
    probe    = prb;
    if (load_flags) begin
      {dec_illegal, dec_is_load, dec_is_store, dec_is_branch, dec_is_jump, dec_wrtEn,
       alu_cond} = nxt_flags;
      load_flags = 1'b0;
    end
    if (rst) exp_hlt = 1'b0;
    e.cyc   = cyc;
    e.ret   = exp_ret;
    e.cause = exp_cause;
    e.hlt   = exp_hlt;
    if (prb || e.imr || e.irw || e.dmr || e.dmw || e.pcw || e.rfw || (exp_hlt && !exp_hlt_prev)) begin
      exp_q.push_back(e);
      name_q.push_back(cur_name);
    end
    exp_hlt_prev = exp_hlt;
    if (e.pcw) exp_ret = exp_ret + 4'd1;
    if (rst) begin
      exp_ret   = 4'd0;
      exp_cause = 2'd0;
    end
  endtask

  task automatic do_reset();
    vec_t z;
    z = mk(0, 0, 0, 0, 0, 2'd0, 0, 0);
    cur_name = "reset";
    tick(1'b1, 1'b0, 1'b0, z, 1'b0);
    tick(1'b1, 1'b1, 1'b1, z, 1'b1);
  endtask

  // Fetch with iw wait cycles, then the class-specific schedule.
  task automatic do_instr(input int cls, input int iw, input int dw, input logic cond,
                          input string nm);
    logic       ld, st, br, jp;
    logic [1:0] sel;
    vec_t       z;
    z  = mk(0, 0, 0, 0, 0, 2'd0, 0, 0);
    ld = (cls == ClsLoad);
    st = (cls == ClsStore);
    br = (cls == ClsBranch);
    jp = (cls == ClsJump);
    cur_name = nm;
    // Jump also raises branch and wrtEn to exercise flag priority.
    nxt_flags  = {1'b0, ld, st, br || jp, jp, (cls == ClsAlu) || ld || jp, cond};
    load_flags = 1'b1;
    for (int k = 0; k <= iw; k++) tick(1'b0, k == iw, 1'b0, mk(1, k == iw, 0, 0, 0, 2'd0, 0, 0), 1'b0);
    tick(1'b0, 1'b0, 1'b0, z, 1'b0);
    if (cls == ClsNop || br || jp) begin
      sel = jp ? 2'd2 : ((br && cond) ? 2'd1 : 2'd0);
      tick(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, sel, 0, 0), 1'b0);
    end else begin
      tick(1'b0, 1'b0, 1'b0, z, 1'b0);
      if (ld || st) begin
        for (int k = 0; k <= dw; k++)
          tick(1'b0, 1'b0, k == dw, mk(0, 0, 1, st, st && (k == dw), 2'd0, 0, 0), 1'b0);
      end
      if (!st) tick(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 2'd0, 1, ld), 1'b0);
    end
  endtask

  // Negedge monitor: pop and compare on every active cycle, summarise when stimulus is done.
  always @(negedge clk) begin
    vec_t  a, e;
    string nm;
    bit    act;
    a = '0;
    a.cyc = cyc; a.imr = imem_req; a.irw = ir_wrtEn; a.dmr = dmem_req; a.dmw = dmem_we;
    a.pcw = pc_wrtEn; a.pcs = pc_sel; a.rfw = regfile_wrtEn; a.wbs = wb_sel; a.hlt = halted;
    a.cause = halt_cause; a.ret = retired;
    act = probe || imem_req || ir_wrtEn || dmem_req || dmem_we || pc_wrtEn || regfile_wrtEn ||
          (halted && !mon_hlt_prev);
    mon_hlt_prev = halted;
    if (act) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output got %s required no activity", fmt(a));
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (a !== e) begin
          n_err++;
          $display("FAIL %s got %s required %s", nm, fmt(a), fmt(e));
        end
      end
    end
    if (done) begin
      n_vec++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL missing_output got %0d pending required 0, next %s %s", exp_q.size(),
                 name_q[0], fmt(exp_q[0]));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout got no finish required finish before 1ms");
    $fatal(1);
  end

  initial begin
    vec_t z;
    z = mk(0, 0, 0, 0, 0, 2'd0, 0, 0);
    do_reset();
    do_instr(ClsAlu,    0, 0, 1'b0, "alu");
    do_instr(ClsLoad,   0, 3, 1'b0, "load_w3");
    do_instr(ClsBranch, 0, 0, 1'b1, "branch_taken");
    do_instr(ClsBranch, 1, 0, 1'b0, "branch_not");
    do_instr(ClsNop,    2, 0, 1'b1, "nop");
    do_instr(ClsStore,  0, 1, 1'b0, "store_w1");
    do_instr(ClsJump,   0, 0, 1'b0, "jump_prio");
    do_instr(ClsNop,   15, 0, 1'b0, "imem_ack_last");
    do_instr(ClsLoad,   0, 15, 1'b0, "dmem_ack_last");

    // Reset in MEM with an ack pending: no retire, no write, back to FETCH with count 0.
    cur_name   = "reset_in_mem";
    nxt_flags  = 7'b0100010;
    load_flags = 1'b1;
    tick(1'b0, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 2'd0, 0, 0), 1'b0);
    tick(1'b0, 1'b0, 1'b0, z, 1'b0);
    tick(1'b0, 1'b0, 1'b0, z, 1'b0);
    tick(1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 2'd0, 0, 0), 1'b0);
    tick(1'b1, 1'b0, 1'b1, z, 1'b0);

    // Illegal opcode halts after DECODE; later acks change nothing.
    do_instr(ClsAlu, 0, 0, 1'b0, "pre_illegal");
    cur_name   = "illegal";
    nxt_flags  = 7'b1000010;
    load_flags = 1'b1;
    tick(1'b0, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 2'd0, 0, 0), 1'b0);
    tick(1'b0, 1'b0, 1'b0, z, 1'b0);
    exp_hlt = 1'b1; exp_cause = 2'd1;
    tick(1'b0, 1'b0, 1'b0, z, 1'b0);
    tick(1'b0, 1'b1, 1'b1, z, 1'b0);
    tick(1'b0, 1'b0, 1'b0, z, 1'b0);
    cur_name = "halt_hold";
    tick(1'b0, 1'b1, 1'b0, z, 1'b1);
    do_reset();

    // Fetch ack withheld for the full budget.
    cur_name = "imem_timeout";
    for (int k = 0; k < 16; k++) tick(1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 2'd0, 0, 0), 1'b0);
    exp_hlt = 1'b1; exp_cause = 2'd2;
    tick(1'b0, 1'b0, 1'b0, z, 1'b0);
    tick(1'b0, 1'b1, 1'b0, z, 1'b1);
    do_reset();

    // Data ack withheld for the full budget.
    cur_name   = "dmem_timeout";
    nxt_flags  = 7'b0010000;
    load_flags = 1'b1;
    tick(1'b0, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 2'd0, 0, 0), 1'b0);
    tick(1'b0, 1'b0, 1'b0, z, 1'b0);
    tick(1'b0, 1'b0, 1'b0, z, 1'b0);
    for (int k = 0; k < 16; k++) tick(1'b0, 1'b0, 1'b0, mk(0, 0, 1, 1, 0, 2'd0, 0, 0), 1'b0);
    exp_hlt = 1'b1; exp_cause = 2'd3;
    tick(1'b0, 1'b0, 1'b0, z, 1'b0);
    tick(1'b0, 1'b0, 1'b1, z, 1'b1);
    do_reset();

    // Sixteen retires wrap the 4-bit counter back to zero.
    for (int n = 0; n < 16; n++) do_instr(ClsNop, 0, 0, 1'b0, "wrap_nop");
    cur_name = "wrap";
    tick(1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 2'd0, 0, 0), 1'b0);

    cur_name = "end";
    tick(1'b1, 1'b0, 1'b0, z, 1'b0);
    done = 1'b1;
  end

endmodule
